// File: rtl/fft_stream_core.sv
// Streaming radix-2 DIT FFT: real samples in, bins out, one butterfly per cycle
// on an in-place register store. Optional alpha-max-beta-min magnitude output.
module fft_stream_core #(
  parameter int SAMPLE_W  = 32,
  parameter int N         = 32,
  parameter int TWIDDLE_W = 16,
  parameter int MAG_MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SAMPLE_W-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SAMPLE_W-1:0]  out_re,
  output logic [SAMPLE_W-1:0]  out_im,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 busy
);

  localparam int LG   = $clog2(N);
  localparam int HALF = N / 2;
  localparam int PW   = SAMPLE_W + TWIDDLE_W;
  localparam int SW1  = SAMPLE_W + 1;
  localparam int SW2  = SAMPLE_W + 2;

  typedef enum logic [1:0] {
    S_LOAD,
    S_COMPUTE,
    S_UNLOAD
  } state_t;

  function automatic logic [LG-1:0] bitrev(
    input logic [LG-1:0] a
  );
    logic [LG-1:0] r;
    r = '0;
    for (int i = 0; i < LG; i++) begin
      r[i] = a[LG-1-i];
    end
    return r;
  endfunction

  // Elaboration-time twiddle: Taylor series, round half away, saturate.
  function automatic logic signed [TWIDDLE_W-1:0] tw_val(
    input int k,
    input bit want_cos
  );
    real x, term, c, s, v, scale;
    int  q, lim;
    x    = 2.0 * 3.14159265358979323846 * k / N;
    c    = 0.0;
    s    = 0.0;
    term = 1.0;
    for (int n = 0; n < 40; n++) begin
      if (n % 4 == 0) c = c + term;
      else if (n % 4 == 1) s = s + term;
      else if (n % 4 == 2) c = c - term;
      else s = s - term;
      term = term * x / (n + 1);
    end
    scale = 2.0 ** (TWIDDLE_W - 1);
    v     = want_cos ? c * scale : -s * scale;
    v     = (v >= 0.0) ? v + 0.5 : v - 0.5;
    q     = $rtoi(v);
    lim   = (1 << (TWIDDLE_W - 1)) - 1;
    if (q > lim) q = lim;
    if (q < -lim) q = -lim;
    return TWIDDLE_W'(q);
  endfunction

  function automatic logic [SAMPLE_W-1:0] mag_est(
    input logic signed [SAMPLE_W-1:0] re,
    input logic signed [SAMPLE_W-1:0] im
  );
    logic [SAMPLE_W-1:0] abs_r, abs_i, mx, mn;
    logic [SAMPLE_W:0]   sum, sat;
    abs_r = re[SAMPLE_W-1] ? SAMPLE_W'(-re) : re;
    abs_i = im[SAMPLE_W-1] ? SAMPLE_W'(-im) : im;
    mx    = (abs_r > abs_i) ? abs_r : abs_i;
    mn    = (abs_r > abs_i) ? abs_i : abs_r;
    sum   = {1'b0, mx} + {2'b00, mn[SAMPLE_W-1:1]};
    sat   = {2'b00, {(SAMPLE_W-1){1'b1}}};
    return (sum > sat) ? sat[SAMPLE_W-1:0] : sum[SAMPLE_W-1:0];
  endfunction

  state_t state, state_nx;

  logic signed [SAMPLE_W-1:0]  mem_re [N];
  logic signed [SAMPLE_W-1:0]  mem_im [N];
  logic signed [TWIDDLE_W-1:0] tw_re  [HALF];
  logic signed [TWIDDLE_W-1:0] tw_im  [HALF];

  logic [LG-1:0] cnt;
  logic [LG-1:0] stg;
  logic [LG-2:0] bfly;

  logic accept, load_done, stage_end, last_bfly;
  logic out_fire, unload_done;

  logic [LG-1:0] jx, hbit, hmask, lo;
  logic [LG-1:0] idx_a, idx_b, tw_sh, rd_idx;
  logic [LG-2:0] tw_idx;

  logic signed [SAMPLE_W-1:0]  ar, ai, br, bi;
  logic signed [TWIDDLE_W-1:0] wr, wi;
  logic signed [PW-1:0]        pr, pi;
  logic signed [SW1-1:0]       tr, ti;
  logic signed [SW2-1:0]       sr0, si0, sr1, si1;
  logic signed [SAMPLE_W-1:0]  nar, nai, nbr, nbi;
  logic signed [SAMPLE_W-1:0]  bin_re, bin_im;
  logic [SAMPLE_W-1:0]         res_re, res_im;

  for (genvar g = 0; g < HALF; g++) begin : g_tw
    localparam logic signed [TWIDDLE_W-1:0] CR = tw_val(g, 1'b1);
    localparam logic signed [TWIDDLE_W-1:0] CI = tw_val(g, 1'b0);
    assign tw_re[g] = CR;
    assign tw_im[g] = CI;
  end

  assign accept      = in_valid && in_ready;
  assign load_done   = accept && (cnt == LG'(N - 1));
  assign stage_end   = (bfly == '1);
  assign last_bfly   = (state == S_COMPUTE) && stage_end &&
                       (stg == LG'(LG - 1));
  assign out_fire    = out_valid && out_ready;
  assign unload_done = (state == S_UNLOAD) && out_fire && out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_LOAD:    if (load_done) state_nx = S_COMPUTE;
      S_COMPUTE: if (last_bfly) state_nx = S_UNLOAD;
      S_UNLOAD:  if (unload_done) state_nx = S_LOAD;
      default:   state_nx = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready = (state == S_LOAD);
    busy     = (state != S_LOAD);
  end

  // cnt wraps to 0 after N accepts, ready for the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      stg  <= '0;
      bfly <= '0;
    end else begin
      if (accept) cnt <= cnt + LG'(1);
      if (state == S_COMPUTE) begin
        bfly <= bfly + (LG-1)'(1);
        if (stage_end) begin
          stg <= (stg == LG'(LG - 1)) ? '0 : stg + LG'(1);
        end
      end
    end
  end

  // butterfly j of stage s: a = group*2h + k, twiddle k*N/(2h)
  always_comb begin
    jx     = {1'b0, bfly};
    hbit   = LG'(1) << stg;
    hmask  = hbit - LG'(1);
    lo     = jx & hmask;
    idx_a  = ((jx & ~hmask) << 1) | lo;
    idx_b  = idx_a | hbit;
    tw_sh  = LG'(LG - 1) - stg;
    tw_idx = (LG-1)'(lo << tw_sh);
  end

  always_comb begin
    ar = mem_re[idx_a];
    ai = mem_im[idx_a];
    br = mem_re[idx_b];
    bi = mem_im[idx_b];
    wr = tw_re[tw_idx];
    wi = tw_im[tw_idx];
    pr = PW'(br) * PW'(wr) - PW'(bi) * PW'(wi);
    pi = PW'(br) * PW'(wi) + PW'(bi) * PW'(wr);
    if (lo == '0) begin
      tr = SW1'(br);
      ti = SW1'(bi);
    end else begin
      tr = SW1'(pr >>> (TWIDDLE_W - 1));
      ti = SW1'(pi >>> (TWIDDLE_W - 1));
    end
    sr0 = SW2'(ar) + SW2'(tr);
    si0 = SW2'(ai) + SW2'(ti);
    sr1 = SW2'(ar) - SW2'(tr);
    si1 = SW2'(ai) - SW2'(ti);
    nar = SAMPLE_W'(sr0 >>> 1);
    nai = SAMPLE_W'(si0 >>> 1);
    nbr = SAMPLE_W'(sr1 >>> 1);
    nbi = SAMPLE_W'(si1 >>> 1);
  end

  // Store is fully rewritten by every load, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_re[bitrev(cnt)] <= in_data;
      mem_im[bitrev(cnt)] <= '0;
    end else if (state == S_COMPUTE) begin
      mem_re[idx_a] <= nar;
      mem_im[idx_a] <= nai;
      mem_re[idx_b] <= nbr;
      mem_im[idx_b] <= nbi;
    end
  end

  always_comb begin
    rd_idx = last_bfly ? '0 : out_idx + LG'(1);
    bin_re = mem_re[rd_idx];
    bin_im = mem_im[rd_idx];
    if (MAG_MODE != 0) begin
      res_re = mag_est(bin_re, bin_im);
      res_im = '0;
    end else begin
      res_re = bin_re;
      res_im = bin_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (last_bfly) begin
      out_valid <= 1'b1;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_re    <= res_re;
      out_im    <= res_im;
    end else if (out_fire) begin
      if (out_last) begin
        out_valid <= 1'b0;
        out_idx   <= '0;
        out_last  <= 1'b0;
      end else begin
        out_idx  <= out_idx + LG'(1);
        out_last <= (out_idx == LG'(N - 2));
        out_re   <= res_re;
        out_im   <= res_im;
      end
    end
  end

endmodule

// File: tb/tb_fft_stream_core.sv
// Directed bench for fft_stream_core: impulse, DC, tone, stalls,
// mid-compute reset, and N=8 / N=1024 impulse sweeps.
module tb_fft_stream_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        out_last, busy;
  logic [31:0] in_data, out_re, out_im;
  logic [4:0]  out_idx;

  logic        in_ready_m, out_valid_m, out_last_m, busy_m;
  logic [31:0] out_re_m, out_im_m;
  logic [4:0]  out_idx_m;

  logic        v8, rdy8, ov8, orr8, ol8, b8;
  logic [15:0] d8, re8, im8;
  logic [2:0]  idx8;

  logic        vk, rdyk, ovk, orrk, olk, bk;
  logic [31:0] dk, rek, imk;
  logic [9:0]  idxk;

  fft_stream_core #(.SAMPLE_W(32), .N(32), .TWIDDLE_W(16), .MAG_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
    .out_last(out_last), .busy(busy)
  );

  fft_stream_core #(.SAMPLE_W(32), .N(32), .TWIDDLE_W(16), .MAG_MODE(1)) dut_m (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data),
    .out_valid(out_valid_m), .out_ready(out_ready),
    .out_re(out_re_m), .out_im(out_im_m), .out_idx(out_idx_m),
    .out_last(out_last_m), .busy(busy_m)
  );

  fft_stream_core #(.SAMPLE_W(16), .N(8), .TWIDDLE_W(16), .MAG_MODE(0)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(rdy8), .in_data(d8),
    .out_valid(ov8), .out_ready(orr8),
    .out_re(re8), .out_im(im8), .out_idx(idx8),
    .out_last(ol8), .busy(b8)
  );

  fft_stream_core #(.SAMPLE_W(32), .N(1024), .TWIDDLE_W(16), .MAG_MODE(0)) dutk (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vk), .in_ready(rdyk), .in_data(dk),
    .out_valid(ovk), .out_ready(orrk),
    .out_re(rek), .out_im(imk), .out_idx(idxk),
    .out_last(olk), .busy(bk)
  );

  int total = 0;
  int bad   = 0;

  int tone_tab[8] = '{1000, 707, 0, -707, -1000, -707, 0, 707};

  longint g_re[32], g_im[32], g_mag[32], g_mim[32];
  longint ref_re[32], ref_im[32];
  int     g_idx[32];
  int     g_last[32];

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input longint obs,
                            input longint exp, input longint tol);
    total++;
    assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  function automatic longint s32(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [31:0] sample(input int kind, input int n);
    if (kind == 0) return (n == 0) ? 32'd1000 : 32'd0;
    if (kind == 1) return 32'd1000;
    return 32'(tone_tab[n % 8]);
  endfunction

  // Loads 32 samples, then counts cycles until out_valid (or abort_at).
  task automatic load_frame(input int kind, input bit gaps,
                            input int abort_at, output int cyc);
    int n, guard, ir_hi;
    n = 0;
    guard = 0;
    ir_hi = 0;
    while (n < 32 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
      end else begin
        in_valid = 1'b1;
        in_data  = sample(kind, n);
      end
      if (in_valid && in_ready) n++;
    end
    check("load_accepts", n, 32);
    cyc = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h5A5A_5A5A;
    while (!out_valid && cyc < 2000) begin
      if (in_ready || !busy) ir_hi++;
      cyc++;
      if (abort_at > 0 && cyc == abort_at) break;
      @(negedge clk);
    end
    check("in_ready_low_compute", ir_hi, 0);
  endtask

  task automatic unload_frame(input bit rnd);
    int got, guard;
    bit held;
    longint h_re;
    int h_idx;
    got = 0;
    guard = 0;
    held = 1'b0;
    h_re = 0;
    h_idx = 0;
    while (got < 32 && guard < 2000) begin
      in_valid = 1'b0;
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_re", s32(out_re), h_re);
        check("hold_idx", out_idx, h_idx);
        held = 1'b0;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        g_re[got]   = s32(out_re);
        g_im[got]   = s32(out_im);
        g_mag[got]  = s32(out_re_m);
        g_mim[got]  = s32(out_im_m);
        g_idx[got]  = int'(out_idx);
        g_last[got] = int'(out_last);
        got++;
      end else if (out_valid) begin
        held  = 1'b1;
        h_re  = s32(out_re);
        h_idx = int'(out_idx);
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    check("unload_count", got, 32);
    check("post_in_ready", in_ready, 1);
    check("post_busy", busy, 0);
    check("post_out_valid", out_valid, 0);
    for (int i = 0; i < 32; i++) begin
      check("bin_idx", g_idx[i], i);
      check("bin_last", g_last[i], (i == 31) ? 1 : 0);
    end
  endtask

  initial begin
    int cyc, n, got, guard;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    v8 = 1'b0; d8 = '0; orr8 = 1'b0;
    vk = 1'b0; dk = '0; orrk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_re", out_re, 0);
    check("rst_out_im", out_im, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);

    // impulse
    load_frame(0, 1'b0, 0, cyc);
    check("imp_compute_cycles", cyc, 80);
    unload_frame(1'b0);
    for (int i = 0; i < 32; i++) begin
      check("imp_re", g_re[i], 31);
      check("imp_im", g_im[i], 0);
    end

    // DC
    load_frame(1, 1'b0, 0, cyc);
    check("dc_compute_cycles", cyc, 80);
    unload_frame(1'b0);
    for (int i = 0; i < 32; i++) begin
      check("dc_re", g_re[i], (i == 0) ? 1000 : 0);
      check("dc_im", g_im[i], 0);
    end
    check("dc_mag0", g_mag[0], 1000);

    // tone at bin 4
    load_frame(2, 1'b0, 0, cyc);
    unload_frame(1'b0);
    for (int i = 0; i < 32; i++) begin
      ref_re[i] = g_re[i];
      ref_im[i] = g_im[i];
      if (i == 4 || i == 28) begin
        check_near("tone_re_peak", g_re[i], 500, 3);
        check_near("tone_mag_peak", g_mag[i], 500, 4);
      end else begin
        check_near("tone_re_floor", g_re[i], 0, 3);
        check_near("tone_mag_floor", g_mag[i], 0, 4);
      end
      check_near("tone_im", g_im[i], 0, 3);
      check("tone_mag_im", g_mim[i], 0);
    end

    // tone again under input gaps and output backpressure
    load_frame(2, 1'b1, 0, cyc);
    check("bp_compute_cycles", cyc, 80);
    unload_frame(1'b1);
    for (int i = 0; i < 32; i++) begin
      check("bp_re", g_re[i], ref_re[i]);
      check("bp_im", g_im[i], ref_im[i]);
    end

    // reset in the middle of COMPUTE
    load_frame(0, 1'b0, 40, cyc);
    in_valid = 1'b0;
    check("pre_abort_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_idx", out_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_frame(1, 1'b0, 0, cyc);
    check("post_abort_cycles", cyc, 80);
    unload_frame(1'b0);
    for (int i = 0; i < 32; i++) begin
      check("post_abort_re", g_re[i], (i == 0) ? 1000 : 0);
      check("post_abort_im", g_im[i], 0);
    end

    // N=8, SAMPLE_W=16 impulse
    n = 0;
    guard = 0;
    while (n < 8 && guard < 100) begin
      @(negedge clk);
      guard++;
      v8 = 1'b1;
      d8 = (n == 0) ? 16'd1000 : 16'd0;
      if (rdy8) n++;
    end
    check("n8_accepts", n, 8);
    @(negedge clk);
    v8 = 1'b0;
    cyc = 0;
    while (!ov8 && cyc < 1000) begin
      cyc++;
      @(negedge clk);
    end
    check("n8_compute_cycles", cyc, 12);
    orr8 = 1'b1;
    got = 0;
    guard = 0;
    while (got < 8 && guard < 100) begin
      if (ov8) begin
        check("n8_re", longint'($signed(re8)), 125);
        check("n8_im", longint'($signed(im8)), 0);
        check("n8_idx", idx8, got);
        check("n8_last", ol8, (got == 7) ? 1 : 0);
        got++;
      end
      @(negedge clk);
      guard++;
    end
    orr8 = 1'b0;
    check("n8_count", got, 8);
    check("n8_done_ready", rdy8, 1);

    // N=1024 impulse
    n = 0;
    guard = 0;
    while (n < 1024 && guard < 3000) begin
      @(negedge clk);
      guard++;
      vk = 1'b1;
      dk = (n == 0) ? 32'd1000 : 32'd0;
      if (rdyk) n++;
    end
    check("n1k_accepts", n, 1024);
    @(negedge clk);
    vk = 1'b0;
    cyc = 0;
    while (!ovk && cyc < 20000) begin
      cyc++;
      @(negedge clk);
    end
    check("n1k_compute_cycles", cyc, 5120);
    orrk = 1'b1;
    got = 0;
    guard = 0;
    while (got < 1024 && guard < 3000) begin
      if (ovk) begin
        check("n1k_re", s32(rek), 0);
        check("n1k_im", s32(imk), 0);
        check("n1k_idx", idxk, got);
        got++;
      end
      @(negedge clk);
      guard++;
    end
    orrk = 1'b0;
    check("n1k_count", got, 1024);
    check("n1k_done_ready", rdyk, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
